// File: rtl/mem_stage.sv
// MIPS MEM stage: passes ALU results through and runs loads/stores over a req/ack data bus.
// Lanes are big-endian; the pipeline is stalled while an access is outstanding.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic [31:0] mem_wdata_o,
    output logic [4:0]  mem_waddr_o,
    output logic        mem_we_o,
    output logic        stall_req_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        logic [3:0] sel;
        sel = 4'b0000;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                case (off)
                    2'd0:    sel = 4'b1000;
                    2'd1:    sel = 4'b0100;
                    2'd2:    sel = 4'b0010;
                    default: sel = 4'b0001;
                endcase
            end
            OP_LH, OP_LHU, OP_SH: sel = off[1] ? 4'b0011 : 4'b1100;
            OP_LW, OP_SW:         sel = 4'b1111;
            default:              sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_repl(input logic [3:0] op, input logic [31:0] sdata);
        logic [31:0] d;
        case (op)
            OP_SB:   d = {4{sdata[7:0]}};
            OP_SH:   d = {2{sdata[15:0]}};
            default: d = sdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (op)
            OP_LB:   d = {{24{b[7]}}, b};
            OP_LBU:  d = {24'd0, b};
            OP_LH:   d = {{16{h[15]}}, h};
            OP_LHU:  d = {16'd0, h};
            default: d = rdata;
        endcase
        return d;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [31:0] r_result;
    logic [3:0]  r_op;
    logic [1:0]  r_off;
    logic        r_abort;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_launch;
    logic        w_r_is_load;

    assign w_is_load   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    assign w_is_store  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    assign w_r_is_load = (r_op >= OP_LB) && (r_op <= OP_LW);

    // Misalignment check on the incoming instruction
    always_comb begin
        w_misalign = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: w_misalign = mem_addr_i[0];
            OP_LW, OP_SW:         w_misalign = (mem_addr_i[1:0] != 2'b00);
            default:              w_misalign = 1'b0;
        endcase
    end

    assign w_launch = (r_state == S_IDLE) && (w_is_load || w_is_store) && !w_misalign;

    // State, counter, latched access and bus request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_result    <= 32'd0;
            r_op        <= 4'd0;
            r_off       <= 2'd0;
            r_abort     <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_sel   <= 4'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_op        <= mem_op_i;
                        r_off       <= mem_addr_i[1:0];
                        r_cnt       <= 16'd0;
                        r_abort     <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_bus_sel   <= lane_sel(mem_op_i, mem_addr_i[1:0]);
                        r_bus_wdata <= store_repl(mem_op_i, mem_sdata_i);
                    end
                end
                S_BUSY: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        if (w_r_is_load) begin
                            r_result <= load_extract(r_op, r_off, bus_rdata_i);
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_bus_req <= 1'b0;
                        r_abort   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt <= 16'd0;
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus_ack_i || (r_cnt == CNT_LAST)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pipeline-facing outputs; gated by reset so they drop immediately
    always_comb begin
        mem_wdata_o = mem_wdata_i;
        mem_waddr_o = mem_waddr_i;
        mem_we_o    = mem_we_i;
        stall_req_o = 1'b0;
        align_err_o = 1'b0;
        bus_err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_load || w_is_store) begin
                    mem_we_o = 1'b0;
                    if (w_misalign) begin
                        align_err_o = !rst;
                    end else begin
                        stall_req_o = !rst;
                    end
                end else begin
                    mem_we_o = mem_we_i;
                end
            end
            S_BUSY: begin
                mem_we_o    = 1'b0;
                stall_req_o = !rst;
            end
            S_DONE: begin
                bus_err_o = r_abort;
                if (w_r_is_load && !r_abort) begin
                    mem_wdata_o = r_result;
                    mem_we_o    = mem_we_i;
                end else begin
                    mem_we_o = 1'b0;
                end
            end
            default: begin
                mem_we_o = 1'b0;
            end
        endcase
    end

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_sel_o   = r_bus_sel;
    assign bus_wdata_o = r_bus_wdata;

endmodule
